tt_um_uio_bus_arbiter: RTL and testbench
========================================

TT_UM_UIO_BUS_ARBITER -- requirements
Module: tt_um_uio_bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles before forced rotation when others are waiting (legal 1..15).
REQ-002 Parameter TURN_CYCLES, default 1, bus-turnaround idle cycles between grants (legal 1..3).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  design enable; low masks all requests.
REQ-006 ui_in  input  8  [3:0] req from requesters 0..3; [7:4] unused.
REQ-007 uio_in  input  8  unused.
REQ-008 uo_out  output  8  [3:0] grant one-hot; [5:4] granted index; [6] busy (GRANT state); [7] turnaround flag (TURN state).
REQ-009 uio_out  output  8  grant counter, count of grants issued, modulo 256.
REQ-010 uio_oe  output  8  8'hFF when ena high, 8'h00 when ena low.

Function
REQ-011 Effective request vector req_e SHALL be ui_in[3:0] AND {4{ena}}.
REQ-012 The FSM SHALL have three states: IDLE, GRANT, TURN, all outputs registered (no combinational path from ui_in to uo_out).
REQ-013 IDLE: if req_e nonzero at a rising edge, select the first set bit scanning from rr_ptr upward, modulo 4; enter GRANT; grant visible the cycle after the sampling edge.
REQ-014 IDLE with req_e zero SHALL remain IDLE with grant 4'b0000.
REQ-015 On each IDLE->GRANT transition: rr_ptr <= (granted index + 1) mod 4; hold counter <= 1; grant counter increments by 1, wrapping 255->0.
REQ-016 GRANT: if req_e[g] low at an edge, enter TURN (grant deasserts the next cycle).
REQ-017 GRANT: if req_e[g] high, hold counter == MAX_HOLD and any other req_e bit set, enter TURN (preemption).
REQ-018 GRANT: if req_e[g] high and no preemption, stay; hold counter increments, saturating at MAX_HOLD.
REQ-019 TURN: grant 4'b0000, uo_out[7]=1 for exactly TURN_CYCLES cycles, then IDLE; requests are not evaluated during TURN.
REQ-020 Minimum gap between grant deassertion and next grant assertion SHALL be TURN_CYCLES + 1 cycles.
REQ-021 ena falling while in GRANT SHALL behave as a request drop (REQ-016).
REQ-022 Grant SHALL never be multi-hot; uo_out[5:4] SHALL hold the last granted index while idle/turn.
REQ-023 Simultaneous requests SHALL be resolved only by rr_ptr; no fixed priority beyond that.

Reset
REQ-024 On rst_n low, immediately: state IDLE, grant 4'b0000, uo_out = 8'h00, rr_ptr = 0, hold counter = 0, grant counter = 0.
REQ-025 Reset asserted mid-GRANT or mid-TURN SHALL abort immediately with no further grant counter update.
REQ-026 First arbitration after reset release SHALL favour requester 0.

Verification
REQ-027 Reset, ena=1, ui_in=4'b1111 held -> grants 0,1,2,3,0 in order, each 8 cycles long, 2 grant-free cycles (1 TURN + 1 IDLE) between, uio_out counts 1..5.
REQ-028 ui_in=4'b0100 held alone for 20 cycles -> grant 4'b0100 continuous for 20 cycles, no preemption, uio_out=1.
REQ-029 Requester 1 granted, drops req after 3 cycles -> uo_out[7]=1 for 1 cycle, then IDLE; new req 4'b0001 -> grant 0 two cycles after drop.
REQ-030 Grant active, ena driven low -> grant released next cycle, uio_oe=8'h00, no new grant while ena low.
REQ-031 rst_n pulsed low mid-GRANT with uio_out=3 -> uo_out=8'h00 and uio_out=0 asynchronously; after release with ui_in=4'b1010 -> grant 1 first.
REQ-032 TURN_CYCLES=3, MAX_HOLD=2 build, ui_in=4'b0011 -> grant 0 for 2 cycles, turnaround flag 3 cycles, grant 1 after 4 grant-free cycles.

Source files
------------

// File: rtl/tt_um_uio_bus_arbiter.sv
// rtl/tt_um_uio_bus_arbiter.sv - four-requester round-robin bus arbiter with hold limit and turnaround
module tt_um_uio_bus_arbiter #(
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    logic [1:0] r_state;
    logic [3:0] r_grant;
    logic [1:0] r_idx;
    logic [1:0] r_rr_ptr;
    logic [3:0] r_hold;
    logic [7:0] r_gcnt;
    logic [1:0] r_turn_cnt;

    logic [3:0] w_req_e;
    logic [1:0] w_sel_idx;
    logic       w_found;
    logic       w_others;
    logic       w_hold_max;
    logic       w_unused;

    assign w_req_e    = ui_in[3:0] & {4{ena}};
    assign w_others   = |(w_req_e & ~r_grant);
    assign w_hold_max = (r_hold == 4'(MAX_HOLD));
    assign w_unused   = ^{uio_in, ui_in[7:4]};

    // First set request scanning upward from the round-robin pointer.
    always_comb begin
        logic [1:0] cand;
        w_sel_idx = 2'd0;
        w_found   = 1'b0;
        cand      = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = r_rr_ptr + 2'(i);
            if (!w_found && w_req_e[cand]) begin
                w_sel_idx = cand;
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= 4'b0000;
            r_idx      <= 2'd0;
            r_rr_ptr   <= 2'd0;
            r_hold     <= 4'd0;
            r_gcnt     <= 8'd0;
            r_turn_cnt <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state  <= S_GRANT;
                        r_grant  <= 4'b0001 << w_sel_idx;
                        r_idx    <= w_sel_idx;
                        r_rr_ptr <= w_sel_idx + 2'd1;
                        r_hold   <= 4'd1;
                        r_gcnt   <= r_gcnt + 8'd1;
                    end
                end
                S_GRANT: begin
                    // A dropped request (including ena low) and a hold-limit preemption both release the bus.
                    if (!w_req_e[r_idx] || (w_hold_max && w_others)) begin
                        r_state    <= S_TURN;
                        r_grant    <= 4'b0000;
                        r_turn_cnt <= 2'(TURN_CYCLES - 1);
                    end else if (!w_hold_max) begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                S_TURN: begin
                    if (r_turn_cnt == 2'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_turn_cnt <= r_turn_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 4'b0000;
                end
            endcase
        end
    end

    assign uo_out  = {r_state == S_TURN, r_state == S_GRANT, r_idx, r_grant};
    assign uio_out = r_gcnt;
    assign uio_oe  = ena ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_tt_um_uio_bus_arbiter.sv
// tb/tb_tt_um_uio_bus_arbiter.sv - scoreboard bench for the round-robin bus arbiter
module tb_tt_um_uio_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] ui_in2 = 8'h00;
    logic [7:0] uo_out2, uio_out2, uio_oe2;

    int errors = 0;
    int checks = 0;

    logic [23:0] exp_q[$];

    tt_um_uio_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    tt_um_uio_bus_arbiter #(.MAX_HOLD(2), .TURN_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in2), .uio_in(8'h00),
        .uo_out(uo_out2), .uio_out(uio_out2), .uio_oe(uio_oe2)
    );

    always #5 clk = ~clk;

    // Reference model of the default build (MAX_HOLD=8, TURN_CYCLES=1).
    int         m_state;
    logic [3:0] m_grant;
    int         m_idx, m_ptr, m_hold, m_turn;
    logic [7:0] m_cnt;

    task automatic model_reset();
        m_state = 0; m_grant = 4'b0000; m_idx = 0; m_ptr = 0; m_hold = 0; m_turn = 0; m_cnt = 8'd0;
    endtask

    task automatic model_edge(input logic [3:0] req);
        logic busy_other;
        busy_other = 1'b0;
        for (int i = 0; i < 4; i++) if (i != m_idx && req[i]) busy_other = 1'b1;
        if (m_state == 0) begin
            for (int i = 0; i < 4; i++) begin
                if (m_state == 0 && req[(m_ptr + i) % 4]) begin
                    m_idx   = (m_ptr + i) % 4;
                    m_state = 1;
                    m_grant = 4'b0000;
                    m_grant[m_idx] = 1'b1;
                    m_hold  = 1;
                    m_cnt   = m_cnt + 8'd1;
                end
            end
            if (m_state == 1) m_ptr = (m_idx + 1) % 4;
        end else if (m_state == 1) begin
            if (!req[m_idx] || (m_hold == 8 && busy_other)) begin
                m_state = 2; m_grant = 4'b0000; m_turn = 1;
            end else if (m_hold < 8) begin
                m_hold = m_hold + 1;
            end
        end else begin
            m_turn = m_turn - 1;
            if (m_turn == 0) m_state = 0;
        end
    endtask

    function automatic logic [7:0] model_uo();
        return {m_state == 2, m_state == 1, 2'(m_idx), m_grant};
    endfunction

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, expv);
        end
    endtask

    task automatic step(input logic [3:0] req, input logic en, input string tag);
        logic [23:0] expv;
        ui_in  = {4'($urandom_range(0, 15)), req};
        uio_in = 8'($urandom);
        ena    = en;
        model_edge(req & {4{en}});
        exp_q.push_back({(en ? 8'hFF : 8'h00), m_cnt, model_uo()});
        @(posedge clk); #1;
        expv = exp_q.pop_front();
        check(tag, {uio_oe, uio_out, uo_out}, expv);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ui_in = 8'h00; ui_in2 = 8'h00; ena = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {uio_oe, uio_out, uo_out}, {8'hFF, 8'h00, 8'h00});
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] exp2[13];
        int guard;
        model_reset();

        // Full contention: grants 0,1,2,3,0 each 8 cycles with 2-cycle gaps.
        do_reset();
        for (int c = 0; c < 50; c++) step(4'b1111, 1'b1, "rr_all");
        check("rr_all_count", {16'h0, uio_out}, {16'h0, 8'd5});

        // Lone requester is never preempted.
        do_reset();
        for (int c = 0; c < 22; c++) step(4'b0100, 1'b1, "lone_req2");
        check("lone_count", {16'h0, uio_out}, {16'h0, 8'd1});

        // Request drop, single turnaround cycle, then regrant.
        do_reset();
        for (int c = 0; c < 4; c++) step(4'b0010, 1'b1, "drop_hold");
        step(4'b0000, 1'b1, "drop_turn");
        check("turn_flag", {16'h0, uo_out}, {16'h0, 8'h90});
        for (int c = 0; c < 4; c++) step(4'b0001, 1'b1, "drop_regrant");

        // ena low acts as a request drop and masks all requests.
        for (int c = 0; c < 5; c++) step(4'b1111, 1'b0, "ena_low");
        for (int c = 0; c < 4; c++) step(4'b1000, 1'b1, "ena_back");

        // Async reset mid-grant, then requester 1 wins first.
        do_reset();
        guard = 0;
        while (!(m_cnt == 8'd3 && m_state == 1) && guard < 200) begin
            step(4'b1111, 1'b1, "to_cnt3");
            guard++;
        end
        check("reach_cnt3", {16'h0, uio_out}, {16'h0, 8'd3});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {8'h00, uio_out, uo_out}, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(4'b1010, 1'b1, "post_reset_first");
        check("post_reset_g1", {20'h0, uo_out[3:0]}, {20'h0, 4'b0010});
        for (int c = 0; c < 6; c++) step(4'b1010, 1'b1, "post_reset_seq");

        // MAX_HOLD=2, TURN_CYCLES=3 build with requesters 0 and 1.
        do_reset();
        exp2 = '{8'h41, 8'h41, 8'h80, 8'h80, 8'h80, 8'h00, 8'h52, 8'h52,
                 8'h90, 8'h90, 8'h90, 8'h10, 8'h41};
        ui_in2 = 8'h03;
        for (int c = 0; c < 13; c++) begin
            exp_q.push_back({16'h0, exp2[c]});
            @(posedge clk); #1;
            check("short_build", {16'h0, uo_out2}, exp_q.pop_front());
        end
        check("short_build_count", {16'h0, uio_out2}, {16'h0, 8'd3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
